main_memory_initiator: RTL and testbench

- Bus-master end of the main-memory interface: takes cache-line fill/writeback and uncached single-access requests from the cache side and sequences them as word accesses on the en/rd_wr/wr_size/addr/data/ready memory bus.
- Owns the tristate data bus while writing and captures read words on ready.
- Returns a single completion per request, with a timeout error if memory never answers.

---
 rtl/main_memory_initiator_pkg.sv | 29 ++
 rtl/main_memory_initiator_wait_timer.sv | 27 ++
 rtl/main_memory_initiator.sv | 126 ++++++++++++
 tb/tb_main_memory_initiator.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/main_memory_initiator_pkg.sv
// Shared definitions for the main-memory bus: size codes, rd/wr polarity,
// initiator FSM encoding and the latched request record.
package main_memory_initiator_pkg;

   localparam logic [1:0] SZ_1B = 2'b00;
   localparam logic [1:0] SZ_2B = 2'b01;
   localparam logic [1:0] SZ_4B = 2'b11;

   localparam logic MEM_RD = 1'b0;
   localparam logic MEM_WR = 1'b1;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_GAP    = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

   typedef struct packed {
      logic        write;
      logic        single;
      logic [1:0]  size;
      logic [31:0] addr;
   } req_t;

   // The unused code 10 is folded onto a full-word access.
   function automatic logic [1:0] norm_size(input logic [1:0] sz);
      return (sz == 2'b10) ? SZ_4B : sz;
   endfunction

endpackage

// File: rtl/main_memory_initiator_wait_timer.sv
// Per-word wait counter; expired flags the last permitted ACCESS cycle.
module mem_wait_timer #(
   parameter int unsigned TIMEOUT = 64
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic inc,
   output logic expired
);

   localparam int unsigned CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk) begin
      if (!reset || clr) begin
         count <= '0;
      end else if (inc && !expired) begin
         count <= count + 1'b1;
      end
   end

   // Count starts at 0 on the first ACCESS cycle, so TIMEOUT-1 marks cycle number TIMEOUT.
   assign expired = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/main_memory_initiator.sv
// Bus-master side of the main-memory interface: sequences line fills/writebacks
// and single uncached accesses as word accesses, with a per-word timeout.
module main_memory_initiator
   import main_memory_initiator_pkg::*;
#(
   parameter int unsigned LINE_WORDS = 4,
   parameter int unsigned TIMEOUT    = 64
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic                       req_write,
   input  logic                       req_single,
   input  logic [1:0]                 req_size,
   input  logic [31:0]                req_addr,
   input  logic [32*LINE_WORDS-1:0]   req_wdata,
   output logic                       resp_valid,
   output logic                       resp_err,
   output logic [32*LINE_WORDS-1:0]   resp_rdata,
   output logic                       mem_en,
   output logic                       mem_rd_wr,
   output logic [1:0]                 mem_wr_size,
   output logic [31:0]                mem_addr,
   inout  logic [31:0]                mem_data,
   input  logic                       mem_ready
);

   localparam int unsigned IW = $clog2(LINE_WORDS);
   localparam int unsigned LW = 32 * LINE_WORDS;

   logic [1:0]    state;
   req_t          req_q;
   logic [LW-1:0] wdata_q;
   logic [LW-1:0] rbuf;
   logic [LW-1:0] rbuf_next;
   logic [IW-1:0] idx;
   logic          err_q;
   logic          last_word;
   logic          tmr_clr;
   logic          tmr_inc;
   logic          tmr_expired;

   mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
      .clk     (clk),
      .reset   (reset),
      .clr     (tmr_clr),
      .inc     (tmr_inc),
      .expired (tmr_expired)
   );

   assign tmr_clr = (state != ST_ACCESS);
   assign tmr_inc = (state == ST_ACCESS) && !mem_ready;

   always_comb begin
      last_word = req_q.single || (idx == IW'(LINE_WORDS - 1));
      rbuf_next = rbuf;
      rbuf_next[{idx, 5'b00000} +: 32] = mem_data;
   end

   // Reads assemble into rbuf; resp_rdata only changes when a read finishes.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= ST_IDLE;
         req_q      <= '0;
         wdata_q    <= '0;
         rbuf       <= '0;
         resp_rdata <= '0;
         idx        <= '0;
         err_q      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  req_q   <= '{write: req_write, single: req_single,
                               size: norm_size(req_size), addr: req_addr};
                  wdata_q <= req_wdata;
                  idx     <= '0;
                  err_q   <= 1'b0;
                  if (!req_write) rbuf <= '0;
                  state   <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               if (mem_ready) begin
                  if (req_q.write == MEM_RD) rbuf <= rbuf_next;
                  if (last_word) begin
                     if (req_q.write == MEM_RD) resp_rdata <= rbuf_next;
                     state <= ST_DONE;
                  end else begin
                     state <= ST_GAP;
                  end
               end else if (tmr_expired) begin
                  err_q <= 1'b1;
                  if (req_q.write == MEM_RD) resp_rdata <= rbuf;
                  state <= ST_DONE;
               end
            end
            ST_GAP: begin
               idx   <= idx + 1'b1;
               state <= ST_ACCESS;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      req_ready   = (state == ST_IDLE);
      resp_valid  = (state == ST_DONE);
      resp_err    = resp_valid && err_q;
      mem_en      = (state == ST_ACCESS);
      mem_rd_wr   = MEM_RD;
      mem_wr_size = '0;
      mem_addr    = '0;
      if (mem_en) begin
         mem_rd_wr   = req_q.write ? MEM_WR : MEM_RD;
         mem_wr_size = req_q.single ? req_q.size : SZ_4B;
         mem_addr    = req_q.single ? req_q.addr
                                    : {req_q.addr[31:IW+2], idx, 2'b00};
      end
   end

   assign mem_data = (mem_en && (mem_rd_wr == MEM_WR)) ? wdata_q[{idx, 5'b00000} +: 32] : 'z;

endmodule

// File: tb/tb_main_memory_initiator.sv
// Scoreboard bench for main_memory_initiator with a simple memory responder.
module tb_main_memory_initiator;

   localparam int unsigned LINE_WORDS = 4;
   localparam int unsigned TIMEOUT    = 64;
   localparam int unsigned LW         = 32 * LINE_WORDS;

   typedef struct {
      logic [31:0] addr;
      logic        wr;
      logic [1:0]  size;
      logic [31:0] data;
   } acc_t;

   typedef struct {
      logic          err;
      logic [LW-1:0] rdata;
      logic [LW-1:0] mask;
      int            t;
      int            lat;
   } resp_t;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic            req_valid = 1'b0;
   logic            req_ready;
   logic            req_write = 1'b0;
   logic            req_single = 1'b0;
   logic [1:0]      req_size = '0;
   logic [31:0]     req_addr = '0;
   logic [LW-1:0]   req_wdata = '0;
   logic            resp_valid;
   logic            resp_err;
   logic [LW-1:0]   resp_rdata;
   logic            mem_en;
   logic            mem_rd_wr;
   logic [1:0]      mem_wr_size;
   logic [31:0]     mem_addr;
   wire  [31:0]     mem_data;
   logic            mem_ready;

   int              n_vec = 0;
   int              n_miss = 0;
   int              cyc = 0;
   int              wcnt = 0;
   int              rdy_wait = 0;
   logic            hang_en = 1'b0;
   logic [31:0]     hang_addr = '0;
   logic            mon_on = 1'b0;
   logic            prev_cmp = 1'b0;
   int              cnt204 = 0;
   int              cnt208 = 0;
   int              n_resp = 0;
   logic [LW-1:0]   model_rdata = '0;
   acc_t            accq[$];
   resp_t           respq[$];

   main_memory_initiator #(.LINE_WORDS(LINE_WORDS), .TIMEOUT(TIMEOUT)) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_write   (req_write),
      .req_single  (req_single),
      .req_size    (req_size),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .resp_valid  (resp_valid),
      .resp_err    (resp_err),
      .resp_rdata  (resp_rdata),
      .mem_en      (mem_en),
      .mem_rd_wr   (mem_rd_wr),
      .mem_wr_size (mem_wr_size),
      .mem_addr    (mem_addr),
      .mem_data    (mem_data),
      .mem_ready   (mem_ready)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_val(input logic [31:0] a);
      return 32'h1000_0000 + {30'b0, a[3:2]};
   endfunction

   // Memory side: returns read data, otherwise pulls the bus to 0 so a stray DUT drive shows up.
   assign mem_data  = (mem_en && mem_rd_wr) ? 'z : (mem_en ? mem_val(mem_addr) : 32'h0);
   assign mem_ready = mem_en && !(hang_en && (mem_addr == hang_addr)) && (wcnt >= rdy_wait);

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_en && !mem_ready) wcnt <= wcnt + 1;
      else                      wcnt <= 0;
   end

   task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (mon_on) begin
         if (mem_en && mem_addr == 32'h204) cnt204++;
         if (mem_en && mem_addr == 32'h208) cnt208++;
         if (prev_cmp) chk("gap_en", LW'(mem_en), LW'(0));
         prev_cmp = mem_en && mem_ready;
         if (mem_en) begin
            if (accq.size() == 0) begin
               chk("acc_extra", LW'(1), LW'(0));
            end else begin
               chk("acc_addr", LW'(mem_addr), LW'(accq[0].addr));
               chk("acc_rdwr", LW'(mem_rd_wr), LW'(accq[0].wr));
               chk("acc_size", LW'(mem_wr_size), LW'(accq[0].size));
               if (accq[0].wr) chk("acc_wdata", LW'(mem_data), LW'(accq[0].data));
               if (mem_ready) void'(accq.pop_front());
            end
         end else begin
            chk("bus_hiz", LW'(mem_data), LW'(0));
         end
         if (resp_valid) begin
            n_resp++;
            if (respq.size() == 0) begin
               chk("resp_extra", LW'(1), LW'(0));
            end else begin
               resp_t r;
               r = respq.pop_front();
               chk("resp_err", LW'(resp_err), LW'(r.err));
               chk("resp_rdata", resp_rdata & r.mask, r.rdata & r.mask);
               chk("resp_lat", LW'(cyc - r.t + 1), LW'(r.lat));
            end
         end
      end
   end

   task automatic send(input logic w, input logic s, input logic [1:0] sz, input logic [31:0] a,
                       input logic [LW-1:0] wd, input int lat, input logic err,
                       input logic [LW-1:0] mask, input logic want_resp, output int t);
      acc_t          ac;
      resp_t         rs;
      logic [LW-1:0] rd;
      req_write  = w;
      req_single = s;
      req_size   = sz;
      req_addr   = a;
      req_wdata  = wd;
      req_valid  = 1'b1;
      t = -1;
      for (int i = 0; i < 300; i++) begin
         if (req_ready) begin
            t = cyc + 1;
            break;
         end
         @(negedge clk);
      end
      if (t < 0) begin
         chk("accept_timeout", LW'(0), LW'(1));
         req_valid = 1'b0;
         return;
      end
      rd = '0;
      if (s) begin
         ac.addr = a;
         ac.wr   = w;
         ac.size = (sz == 2'b10) ? 2'b11 : sz;
         ac.data = wd[31:0];
         accq.push_back(ac);
         rd[31:0] = mem_val(a);
      end else begin
         for (int k = 0; k < LINE_WORDS; k++) begin
            ac.addr = (a & ~32'(LINE_WORDS * 4 - 1)) + 32'(k * 4);
            ac.wr   = w;
            ac.size = 2'b11;
            ac.data = wd[32*k +: 32];
            accq.push_back(ac);
            rd[32*k +: 32] = mem_val(ac.addr);
         end
      end
      if (!w) model_rdata = rd;
      rs.err   = err;
      rs.rdata = model_rdata;
      rs.mask  = mask;
      rs.t     = t;
      rs.lat   = lat;
      if (want_resp) respq.push_back(rs);
      @(negedge clk);
   endtask

   task automatic wait_idle();
      int i;
      for (i = 0; i < 400; i++) begin
         if (respq.size() == 0 && req_ready) break;
         @(negedge clk);
      end
      if (i == 400) chk("idle_timeout", LW'(0), LW'(1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int            t;
      int            t1;
      int            t2;
      int            s204;
      int            s208;
      int            sresp;
      int            i;
      logic [LW-1:0] wd;

      reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_req_ready", LW'(req_ready), LW'(1));
      chk("rst_resp_valid", LW'(resp_valid), LW'(0));
      chk("rst_resp_err", LW'(resp_err), LW'(0));
      chk("rst_mem_en", LW'(mem_en), LW'(0));
      chk("rst_mem_rd_wr", LW'(mem_rd_wr), LW'(0));
      chk("rst_mem_wr_size", LW'(mem_wr_size), LW'(0));
      chk("rst_mem_addr", LW'(mem_addr), LW'(0));
      chk("rst_mem_data", LW'(mem_data), LW'(0));
      chk("rst_resp_rdata", resp_rdata, LW'(0));
      reset  = 1'b1;
      mon_on = 1'b1;
      @(negedge clk);

      // line read, ready on first cycle
      rdy_wait = 0;
      send(1'b0, 1'b0, 2'b11, 32'h0000_012C, '0, 2 * LINE_WORDS, 1'b0, '1, 1'b1, t);
      req_valid = 1'b0;
      wait_idle();
      chk("read_left", LW'(accq.size()), LW'(0));

      // line write, 3 wait cycles per word; rdata must still hold the read line
      rdy_wait = 3;
      wd = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
      send(1'b1, 1'b0, 2'b11, 32'h0000_0540, wd, LINE_WORDS * (rdy_wait + 2), 1'b0, '1, 1'b1, t);
      req_valid = 1'b0;
      wait_idle();
      chk("write_left", LW'(accq.size()), LW'(0));

      // single write, half-word at odd address
      rdy_wait = 0;
      send(1'b1, 1'b1, 2'b01, 32'h0000_0203, LW'(32'h0000_BEEF), 2, 1'b0, '1, 1'b1, t);
      req_valid = 1'b0;
      wait_idle();

      // single read with one wait cycle
      rdy_wait = 1;
      send(1'b0, 1'b1, 2'b01, 32'h0000_0346, '0, 3, 1'b0, '1, 1'b1, t);
      req_valid = 1'b0;
      wait_idle();

      // timeout on word 1 of a line read
      rdy_wait  = 0;
      hang_en   = 1'b1;
      hang_addr = 32'h0000_0204;
      s204 = cnt204;
      s208 = cnt208;
      send(1'b0, 1'b0, 2'b11, 32'h0000_0200, '0, 2 + TIMEOUT + 1, 1'b1, LW'(32'hFFFF_FFFF), 1'b1, t);
      req_valid = 1'b0;
      wait_idle();
      chk("to_cycles", LW'(cnt204 - s204), LW'(TIMEOUT));
      chk("to_word2", LW'(cnt208 - s208), LW'(0));
      chk("to_left", LW'(accq.size()), LW'(LINE_WORDS - 1));
      accq.delete();
      hang_en = 1'b0;

      // reset during the third ACCESS of a line write
      wd = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
      send(1'b1, 1'b0, 2'b11, 32'h0000_0300, wd, 0, 1'b0, '1, 1'b0, t);
      req_valid = 1'b0;
      for (i = 0; i < 50; i++) begin
         if (mem_en && mem_addr == 32'h0000_0308) break;
         @(negedge clk);
      end
      chk("mid_find", LW'(i < 50), LW'(1));
      sresp = n_resp;
      reset = 1'b0;
      @(negedge clk);
      chk("mid_mem_en", LW'(mem_en), LW'(0));
      chk("mid_mem_data", LW'(mem_data), LW'(0));
      chk("mid_req_ready", LW'(req_ready), LW'(1));
      chk("mid_resp_valid", LW'(resp_valid), LW'(0));
      chk("mid_resp_rdata", resp_rdata, LW'(0));
      reset = 1'b1;
      accq.delete();
      model_rdata = '0;
      repeat (30) @(negedge clk);
      chk("mid_no_resp", LW'(n_resp - sresp), LW'(0));

      // back-to-back with req_valid held; size 10 becomes a word access
      rdy_wait = 0;
      send(1'b1, 1'b1, 2'b10, 32'h0000_0400, LW'(32'h1234_5678), 2, 1'b0, '1, 1'b1, t1);
      send(1'b0, 1'b1, 2'b11, 32'h0000_0344, '0, 2, 1'b0, '1, 1'b1, t2);
      req_valid = 1'b0;
      wait_idle();
      chk("b2b_accept", LW'(t2 - t1), LW'(3));
      chk("b2b_left", LW'(accq.size()), LW'(0));

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
